// File: rtl/wb_arbiter_pkg.sv
// Shared writeback packet type and small helpers for the writeback arbiter slice.
package wb_arbiter_pkg;

    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [1:0]  epoch;
        logic        is_branch;
        logic        mispredict;
        logic [15:0] data;
    } fu_wb_t;

    // Modulo-n increment by explicit compare, so non-power-of-two sizes wrap correctly.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v == n - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/wb_port_fifo.sv
// Per-FU circular writeback buffer with occupancy count; flush empties it in one edge.
module wb_port_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  fu_wb_t                       din,
    output fu_wb_t                       head,
    output logic [$clog2(DEPTH+1)-1:0]   cnt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fu_wb_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= PW'(wrap_inc(32'(wr_ptr), DEPTH));
            end
            if (pop) rd_ptr <= PW'(wrap_inc(32'(rd_ptr), DEPTH));
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (cnt == ($clog2(DEPTH+1))'(DEPTH))));

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin merge of N_FU writeback streams onto the single ROB writeback port,
// holding the granted packet stable while the ROB stalls.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned N_FU      = 4,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_FU-1:0]           fu_valid,
    output logic [N_FU-1:0]           fu_ready,
    input  fu_wb_t [N_FU-1:0]         fu_pkt,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output fu_wb_t                    wb_pkt,
    input  logic                      flush_valid,
    output logic [$clog2(N_FU)-1:0]   wb_grant_idx
);

    localparam int unsigned IW = $clog2(N_FU);
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    logic [CW-1:0]   cnt  [N_FU];
    fu_wb_t          head [N_FU];
    logic [N_FU-1:0] pend;
    logic [N_FU-1:0] pop;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   lock_idx;
    logic            lock;
    logic [IW-1:0]   grant;
    logic            any_pend;
    logic            fire;

    for (genvar k = 0; k < N_FU; k++) begin : g_port
        assign pend[k]     = (cnt[k] != '0);
        assign fu_ready[k] = (cnt[k] != CW'(BUF_DEPTH)) && !flush_valid;
        assign pop[k]      = fire && (grant == IW'(k));

        wb_port_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush_valid),
            .push  (fu_valid[k] && fu_ready[k]),
            .pop   (pop[k]),
            .din   (fu_pkt[k]),
            .head  (head[k]),
            .cnt   (cnt[k])
        );
    end

    // Lock overrides the search so a stalled packet cannot be preempted.
    always_comb begin
        int unsigned j;
        logic        found;
        grant = '0;
        found = 1'b0;
        j     = 0;
        if (lock) begin
            grant = lock_idx;
        end else begin
            for (int unsigned i = 0; i < N_FU; i++) begin
                j = 32'(rr) + i;
                if (j >= N_FU) j = j - N_FU;
                if (!found && pend[IW'(j)]) begin
                    grant = IW'(j);
                    found = 1'b1;
                end
            end
        end
    end

    assign any_pend     = |pend;
    assign wb_valid     = any_pend && !flush_valid;
    assign fire         = wb_valid && wb_ready;
    assign wb_grant_idx = any_pend ? grant : '0;
    assign wb_pkt       = head[grant];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr       <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (flush_valid) begin
            rr       <= '0;
            lock     <= 1'b0;
        end else if (fire) begin
            rr       <= IW'(wrap_inc(32'(grant), N_FU));
            lock     <= 1'b0;
        end else if (wb_valid) begin
            lock     <= 1'b1;
            lock_idx <= grant;
        end
    end

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (wb_valid && !wb_ready) |=> $stable(wb_pkt));

    a_no_valid_in_flush: assert property (@(posedge clk) disable iff (!rst_n)
        flush_valid |-> !wb_valid);

endmodule
